// File: rtl/lowpass_cal_pkg.sv
// Shared types and sizing helpers for the lowpass corner calibration sequencer.
package lowpass_cal_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DECIDE = 2'd3
  } cal_state_e;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold a count of 0..n.
  function automatic int ones_w(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

  // Minimum number of ones for a majority of n samples.
  function automatic int vote_thr(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/lowpass_corner_cal_if.sv
// Control/status bundle between the register bank, the filter trim input and the sequencer.
interface lowpass_corner_cal_if #(
  parameter int CODE_W = 6
);
  logic              start_i;
  logic              abort_i;
  logic              cmp_i;
  logic [CODE_W-1:0] trim_o;
  logic              stim_en_o;
  logic              busy_o;
  logic              done_o;
  logic              cal_valid_o;
  logic              sat_o;

  modport master (
    output start_i, abort_i, cmp_i,
    input  trim_o, stim_en_o, busy_o, done_o, cal_valid_o, sat_o
  );

  modport slave (
    input  start_i, abort_i, cmp_i,
    output trim_o, stim_en_o, busy_o, done_o, cal_valid_o, sat_o
  );
endinterface

// File: rtl/lowpass_cal_vote.sv
// Majority voter: counts comparator samples and ones, flags the last sample.
module lowpass_cal_vote
  import lowpass_cal_pkg::*;
#(
  parameter int VOTE_N = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic cmp,
  output logic last,
  output logic vote
);
  localparam int SW = cnt_w(VOTE_N);
  localparam int OW = ones_w(VOTE_N);

  logic [SW-1:0] smp_cnt;
  logic [OW-1:0] ones;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      smp_cnt <= '0;
      ones    <= '0;
    end else if (enable) begin
      smp_cnt <= smp_cnt + 1'b1;
      ones    <= ones + OW'(cmp);
    end
  end

  assign last = (smp_cnt == SW'(VOTE_N - 1));
  assign vote = (ones >= OW'(vote_thr(VOTE_N)));

endmodule

// File: rtl/lowpass_corner_cal.sv
// SAR calibration of the lowpass filter capacitor trim: settle, vote, keep/clear each bit MSB first.
module lowpass_corner_cal
  import lowpass_cal_pkg::*;
#(
  parameter int CODE_W       = 6,
  parameter int SETTLE_CYC   = 64,
  parameter int VOTE_N       = 5,
  parameter int DEFAULT_CODE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lowpass_corner_cal_if.slave  cal
);
  localparam int PW  = cnt_w(CODE_W);
  localparam int STW = cnt_w(SETTLE_CYC);

  cal_state_e        state, state_nxt;
  logic [STW-1:0]    settle_cnt, settle_nxt;
  logic [PW-1:0]     ptr, ptr_nxt;
  logic [CODE_W-1:0] trim, trim_nxt, result, result_nxt, code;
  logic              saved_valid, saved_valid_nxt;
  logic              busy, busy_nxt, stim_en, stim_nxt, done, done_nxt;
  logic              cal_valid, cal_valid_nxt, sat, sat_nxt;
  logic              vote_clear, vote_en, vote_last, vote;

  lowpass_cal_vote #(.VOTE_N(VOTE_N)) u_vote (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (vote_clear),
    .enable (vote_en),
    .cmp    (cal.cmp_i),
    .last   (vote_last),
    .vote   (vote)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    settle_nxt      = settle_cnt;
    ptr_nxt         = ptr;
    trim_nxt        = trim;
    result_nxt      = result;
    saved_valid_nxt = saved_valid;
    busy_nxt        = busy;
    stim_nxt        = stim_en;
    done_nxt        = 1'b0;
    cal_valid_nxt   = cal_valid;
    sat_nxt         = sat;
    vote_clear      = 1'b1;
    vote_en         = 1'b0;
    code            = trim;

    case (state)
      IDLE: begin
        if (cal.start_i && !cal.abort_i) begin
          state_nxt       = SETTLE;
          trim_nxt        = {1'b1, {(CODE_W-1){1'b0}}};
          ptr_nxt         = PW'(CODE_W - 1);
          settle_nxt      = '0;
          stim_nxt        = 1'b1;
          busy_nxt        = 1'b1;
          cal_valid_nxt   = 1'b0;
          saved_valid_nxt = cal_valid;
        end
      end
      SETTLE: begin
        if (settle_cnt == STW'(SETTLE_CYC - 1)) begin
          state_nxt  = SAMPLE;
          settle_nxt = '0;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end
      SAMPLE: begin
        vote_clear = 1'b0;
        vote_en    = 1'b1;
        if (vote_last) state_nxt = DECIDE;
      end
      DECIDE: begin
        if (!vote) code[ptr] = 1'b0;
        if (ptr != '0) begin
          code[ptr - 1'b1] = 1'b1;
          ptr_nxt    = ptr - 1'b1;
          settle_nxt = '0;
          state_nxt  = SETTLE;
        end else begin
          result_nxt    = code;
          sat_nxt       = (code == '0) || (code == '1);
          done_nxt      = 1'b1;
          busy_nxt      = 1'b0;
          stim_nxt      = 1'b0;
          cal_valid_nxt = 1'b1;
          state_nxt     = IDLE;
        end
        trim_nxt = code;
      end
      default: state_nxt = IDLE;
    endcase

    // Abort restores the last good result and its validity from before the start.
    if (state != IDLE && cal.abort_i) begin
      state_nxt     = IDLE;
      trim_nxt      = result;
      result_nxt    = result;
      cal_valid_nxt = saved_valid;
      busy_nxt      = 1'b0;
      stim_nxt      = 1'b0;
      done_nxt      = 1'b0;
      sat_nxt       = sat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_cnt  <= '0;
      ptr         <= '0;
      trim        <= CODE_W'(DEFAULT_CODE);
      result      <= CODE_W'(DEFAULT_CODE);
      saved_valid <= 1'b0;
      busy        <= 1'b0;
      stim_en     <= 1'b0;
      done        <= 1'b0;
      cal_valid   <= 1'b0;
      sat         <= 1'b0;
    end else begin
      settle_cnt  <= settle_nxt;
      ptr         <= ptr_nxt;
      trim        <= trim_nxt;
      result      <= result_nxt;
      saved_valid <= saved_valid_nxt;
      busy        <= busy_nxt;
      stim_en     <= stim_nxt;
      done        <= done_nxt;
      cal_valid   <= cal_valid_nxt;
      sat         <= sat_nxt;
    end
  end

  assign cal.trim_o      = trim;
  assign cal.stim_en_o   = stim_en;
  assign cal.busy_o      = busy;
  assign cal.done_o      = done;
  assign cal.cal_valid_o = cal_valid;
  assign cal.sat_o       = sat;

endmodule
